// File: rtl/instr_encoder_pkg.sv
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared RV32I definitions for the instruction encoder.
//                Major opcodes, func3 codes, instruction format codes and
//                immediate range limits, plus an opcode -> format lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

  // Major opcodes
  localparam logic [6:0] RISCV_OP       = 7'b0110011;
  localparam logic [6:0] RISCV_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RISCV_LOAD     = 7'b0000011;
  localparam logic [6:0] RISCV_JALR     = 7'b1100111;
  localparam logic [6:0] RISCV_MEM_MISC = 7'b0001111;
  localparam logic [6:0] RISCV_SYSTEM   = 7'b1110011;
  localparam logic [6:0] RISCV_STORE    = 7'b0100011;
  localparam logic [6:0] RISCV_BRANCH   = 7'b1100011;
  localparam logic [6:0] RISCV_LUI      = 7'b0110111;
  localparam logic [6:0] RISCV_AUIPC    = 7'b0010111;
  localparam logic [6:0] RISCV_JAL      = 7'b1101111;

  // func3 codes that matter for legality
  localparam logic [2:0] F3_ADD_SUB  = 3'b000;
  localparam logic [2:0] F3_SLL      = 3'b001;
  localparam logic [2:0] F3_SRL_SRA  = 3'b101;
  localparam logic [2:0] F3_SW       = 3'b010;
  localparam logic [2:0] F3_BR_RSV0  = 3'b010;
  localparam logic [2:0] F3_BR_RSV1  = 3'b011;
  localparam logic [2:0] F3_FENCE    = 3'b000;

  localparam logic [6:0] F7_NORMAL   = 7'h00;
  localparam logic [6:0] F7_ALT      = 7'h20;

  // Immediate range limits (signed byte values)
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      RISCV_OP:                                  return FMT_R;
      RISCV_OP_IMM, RISCV_LOAD, RISCV_JALR,
      RISCV_MEM_MISC, RISCV_SYSTEM:              return FMT_I;
      RISCV_STORE:                               return FMT_S;
      RISCV_BRANCH:                              return FMT_B;
      RISCV_LUI, RISCV_AUIPC:                    return FMT_U;
      RISCV_JAL:                                 return FMT_J;
      default:                                   return FMT_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_field_pack.sv
// ============================================================================
//  Module      : encoder_field_pack
//  Description : Combinational packer: field bundle -> 32-bit RV32I word plus
//                an illegal-bundle flag. Illegal bundles produce word 0.
//  Ports       : opcode/func3/func7/rs1/rs2/rd/imm in; instr[31:0], err out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e        fmt;
  logic        is_shift;
  logic        imm12_ok;
  logic        immb_ok;
  logic        immj_ok;
  logic        f7_ok;
  logic [31:0] packed_word;
  logic        illegal;

  always_comb begin
    fmt      = fmt_of(opcode);
    // Shift-immediates carry func7 in the top bits and a 5-bit shamt.
    is_shift = (opcode == RISCV_OP_IMM) &&
               ((func3 == F3_SLL) || (func3 == F3_SRL_SRA));
    imm12_ok = ($signed(imm) >= IMM_I_MIN) && ($signed(imm) <= IMM_I_MAX);
    immb_ok  = !imm[0] && ($signed(imm) >= IMM_B_MIN) && ($signed(imm) <= IMM_B_MAX);
    immj_ok  = !imm[0] && ($signed(imm) >= IMM_J_MIN) && ($signed(imm) <= IMM_J_MAX);
    // The alternate func7 selects SUB / SRA / SRAI only.
    f7_ok    = (func7 == F7_NORMAL) ||
               ((func7 == F7_ALT) && ((func3 == F3_SRL_SRA) ||
                                      ((func3 == F3_ADD_SUB) && !is_shift && (fmt == FMT_R))));

    packed_word = 32'h0;
    illegal     = 1'b0;

    case (fmt)
      FMT_R: begin
        packed_word = {func7, rs2, rs1, func3, rd, opcode};
        illegal     = !f7_ok;
      end
      FMT_I: begin
        if (is_shift) begin
          packed_word = {func7, imm[4:0], rs1, func3, rd, opcode};
          illegal     = (imm[31:5] != 27'h0) || !f7_ok;
        end else begin
          packed_word = {imm[11:0], rs1, func3, rd, opcode};
          illegal     = !imm12_ok ||
                        ((opcode == RISCV_MEM_MISC) && (func3 != F3_FENCE));
        end
      end
      FMT_S: begin
        packed_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        illegal     = !imm12_ok || (func3 > F3_SW);
      end
      FMT_B: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        illegal     = !immb_ok || (func3 == F3_BR_RSV0) || (func3 == F3_BR_RSV1);
      end
      FMT_U: begin
        packed_word = {imm[31:12], rd, opcode};
        illegal     = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        illegal     = !immj_ok;
      end
      default: begin
        packed_word = 32'h0;
        illegal     = 1'b1;
      end
    endcase

    instr = illegal ? 32'h0 : packed_word;
    err   = illegal;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : RV32I instruction encoder with valid/ready input, one-stage
//                registered output tagged with a memory address, legality
//                flag and saturating error counter.
//  Ports       : clk, rst_n (async, active low), restart (sync pulse)
//                in_valid/in_ready + in_* field bundle
//                out_valid/out_ready + out_instr/out_addr/out_err
//                err_count - saturating count of emitted illegal bundles
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_func3,
  input  logic [6:0]           in_func7,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;
  logic        out_hs;

  encoder_field_pack u_pack (
    .opcode (in_opcode),
    .func3  (in_func3),
    .func7  (in_func7),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .rd     (in_rd),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // The output register may be refilled in the same cycle it is drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
      err_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= pack_instr;
        out_err   <= pack_err;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      // restart takes priority over the advance of a coincident handshake,
      // so the next word emitted is tagged BASE_ADDR.
      if (restart) begin
        out_addr  <= BASE_ADDR;
        err_count <= '0;
      end else if (out_hs) begin
        out_addr <= out_addr + 32'd4;
        if (out_err && (err_count != {ERR_CNT_W{1'b1}})) begin
          err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none

module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_opcode = '0;
  logic [2:0]    in_func3 = '0;
  logic [6:0]    in_func7 = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic          out_err;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (from the ISA field rules) -------------
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] d, input logic [31:0] imm);
    int          s;
    logic [31:0] w;
    bit          e;
    logic [31:0] common;
    s      = signed'(imm);
    common = (32'(r1) << 15) | (32'(f3) << 12) | 32'(op);
    e = 0;
    w = 0;
    case (op)
      7'b0110011: begin
        e = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        w = (32'(f7) << 25) | (32'(r2) << 20) | common | (32'(d) << 7);
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        if (op == 7'b0010011 && (f3 == 1 || f3 == 5)) begin
          e = (imm / 32) != 0 || !(f7 == 0 || (f7 == 7'h20 && f3 == 5));
          w = (32'(f7) << 25) | ((imm % 32) << 20) | common | (32'(d) << 7);
        end else begin
          e = s < -2048 || s > 2047 || (op == 7'b0001111 && f3 != 0);
          w = ((imm & 32'hfff) << 20) | common | (32'(d) << 7);
        end
      end
      7'b0100011: begin
        e = s < -2048 || s > 2047 || f3 > 2;
        w = (((imm >> 5) & 32'h7f) << 25) | (32'(r2) << 20) | common | ((imm & 32'h1f) << 7);
      end
      7'b1100011: begin
        e = (s % 2) != 0 || s < -4096 || s > 4094 || f3 == 2 || f3 == 3;
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (32'(r2) << 20) | common
          | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
      end
      7'b0110111, 7'b0010111: begin
        e = (imm % 4096) != 0;
        w = (imm & 32'hffff_f000) | (32'(d) << 7) | 32'(op);
      end
      7'b1101111: begin
        e = (s % 2) != 0 || s < -(1 << 20) || s > (1 << 20) - 2;
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) & 32'hff) << 12) | (32'(d) << 7) | 32'(op);
      end
      default: e = 1;
    endcase
    if (e) w = 0;
    return {e, w};
  endfunction

  // ---------------- scoreboard + monitor -----------------------------------
  logic [32:0]   exp_q[$];
  logic [31:0]   m_addr = BASE;
  int            m_cnt  = 0;
  bit            have_hold = 0;
  logic [31:0]   hold_instr;
  logic          hold_err;

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_err", out_err, 0);
      chk("rst_addr", out_addr, BASE);
      chk("rst_cnt", err_count, 0);
      exp_q.delete();
      m_addr    = BASE;
      m_cnt     = 0;
      have_hold = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (have_hold && out_valid) begin
        chk("hold_instr", out_instr, hold_instr);
        chk("hold_err", out_err, hold_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word_instr", out_instr, e[31:0]);
          chk("word_err", out_err, e[32]);
          chk("word_addr", out_addr, m_addr);
          chk("err_count", err_count, m_cnt);
          if (!restart) begin
            m_addr = m_addr + 4;
            if (out_err && m_cnt < (1 << CW) - 1) m_cnt++;
          end
        end
      end
      if (restart) begin
        m_addr = BASE;
        m_cnt  = 0;
      end
      have_hold  = out_valid && !out_ready;
      hold_instr = out_instr;
      hold_err   = out_err;
      if (in_valid && in_ready)
        exp_q.push_back(ref_encode(in_opcode, in_func3, in_func7, in_rs1, in_rs2, in_rd, in_imm));
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d, input logic [31:0] imm);
    in_opcode = op; in_func3 = f3; in_func7 = f7;
    in_rs1 = r1; in_rs2 = r2; in_rd = d; in_imm = imm;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d, input logic [31:0] imm);
    bit ok;
    ok = 0;
    set_fields(op, f3, f7, r1, r2, d, imm);
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 10000)) - 32'd5000;
      1: return $urandom;
      2: return $urandom & 32'hffff_f000;
      3: case ($urandom_range(0, 7))
           0: return 32'd2047;   1: return 32'hffff_f800; 2: return 32'd2048;
           3: return 32'd4094;   4: return 32'hffff_f000; 5: return 32'h000f_fffe;
           6: return 32'hfff0_0000; default: return 32'h0010_0000;
         endcase
      4: return 32'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  logic [6:0] ops[11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111,
                          7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                          7'b1101111};

  initial begin
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_in_ready", in_ready, 1);

    // ADDI x1,x0,5: one cycle latency, tagged BASE
    out_ready = 1'b1;
    send(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);
    chk("addi_valid", out_valid, 1);
    chk("addi_instr", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, BASE);

    // Back-to-back SW, BEQ, LUI, JAL
    send(7'b0100011, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8);
    chk("sw_instr", out_instr, 32'h0020A423);
    send(7'b1100011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hffff_fffc);
    chk("beq_instr", out_instr, 32'hFE000EE3);
    send(7'b0110111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
    chk("lui_instr", out_instr, 32'h123452B7);
    send(7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048);
    chk("jal_instr", out_instr, 32'h001000EF);
    chk("jal_addr", out_addr, BASE + 32'd16);

    // Illegal bundles
    send(7'b1100011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3);
    chk("beq_odd_err", out_err, 1);
    chk("beq_odd_instr", out_instr, 0);
    send(7'b0100011, 3'b011, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4);
    chk("store_f3_err", out_err, 1);
    chk("store_f3_instr", out_instr, 0);
    cyc();
    chk("err_count_2", err_count, 2);
    chk("err_addr_adv", out_addr, BASE + 32'd28);

    // Back-pressure: word held, input stalled for 3 cycles
    out_ready = 1'b0;
    send(7'b0110011, 3'b000, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
    set_fields(7'b0010011, 3'b101, 7'h20, 5'd6, 5'd0, 5'd7, 32'd9);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    send(7'b0010011, 3'b101, 7'h20, 5'd6, 5'd0, 5'd7, 32'd9);
    cyc();

    // restart coincident with an output handshake
    send(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd2, 32'd1);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_addr", out_addr, BASE);
    chk("restart_cnt", err_count, 0);
    send(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd3, 32'd2);
    chk("after_restart_addr", out_addr, BASE);
    cyc();

    // restart while a word is pending retags it
    out_ready = 1'b0;
    send(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd4, 32'd3);
    chk("pending_addr", out_addr, BASE + 32'd4);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("retag_addr", out_addr, BASE);
    out_ready = 1'b1;
    cyc();

    // Saturation of the error counter
    for (int i = 0; i < 9; i++) send(7'b0000000, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    cyc();
    chk("err_sat", err_count, 3'b111);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(7'b0110111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd9, 32'hABCD_E000);
    set_fields(7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd4);
    in_valid = 1'b1;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_addr", out_addr, BASE);
    in_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);
    chk("post_reset_addr", out_addr, BASE);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [6:0] op;
      logic [6:0] f7;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      set_fields(op, 3'($urandom), f7, 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      restart   = ($urandom_range(0, 63) == 0);
      cyc();
    end

    // Drain
    in_valid  = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("drain_valid", out_valid, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
